process_clk_monitor: RTL and testbench

//   Consumes the divided process clock produced by the process-clock divider and re-expresses it in
//   the I_CLK domain. Outputs: one-cycle tick per process-clock rising edge, measured period,

---
 rtl/process_clk_monitor.sv | 152 +++++++++++++++
 tb/tb_process_clk_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/process_clk_monitor.sv
// Re-expresses the divided process clock I_PCLK in the I_CLK domain: tick, period, lock/loss, miss count.
// Optional macro PCLK_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detector.
module process_clk_monitor #(
    parameter int EXP_PERIOD = 4,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic             I_PCLK,
    input  logic             I_CLR,
    output logic             O_TICK,
    output logic [CNT_W-1:0] O_PERIOD,
    output logic             O_PERIOD_VLD,
    output logic             O_LOCKED,
    output logic             O_LOSS,
    output logic [7:0]       O_MISS_CNT
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] EXP_C  = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT - 1);
    localparam logic [MW-1:0]    LOCK_C = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, LOST} state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc_miss(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, meas;
    logic [MW-1:0]    match, match_n;
    logic [7:0]       miss_n;
    logic             miss_inc, per_upd;
    logic             pclk_s, pclk_dly, rise;

    // Stage p0/p1: input capture of I_PCLK
`ifdef PCLK_SYNC_EN
    logic pclk_p0, pclk_p1;
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            pclk_p0 <= 1'b0;
            pclk_p1 <= 1'b0;
        end else begin
            pclk_p0 <= I_PCLK;
            pclk_p1 <= pclk_p0;
        end
    end
    assign pclk_s = pclk_p1;
`else
    logic pclk_p0;
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) pclk_p0 <= 1'b0;
        else     pclk_p0 <= I_PCLK;
    end
    assign pclk_s = pclk_p0;
`endif

    // Edge detect stage
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) pclk_dly <= 1'b0;
        else     pclk_dly <= pclk_s;
    end
    assign rise = pclk_s & ~pclk_dly;
    assign meas = sat_inc_cnt(cnt);

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        match_n  = match;
        miss_inc = 1'b0;
        per_upd  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = MEASURE;
                    match_n = '0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    per_upd = 1'b1;
                    if (meas == EXP_C) begin
                        match_n = match + MW'(1);
                        if (match_n == LOCK_C) state_n = LOCKED;
                    end else begin
                        match_n = '0;
                    end
                end else if (cnt == TMO_C) begin
                    state_n = LOST;
                end
            end
            LOCKED: begin
                if (rise) begin
                    per_upd = 1'b1;
                    if (meas != EXP_C) begin
                        state_n  = MEASURE;
                        match_n  = '0;
                        miss_inc = 1'b1;
                    end
                end else if (cnt == TMO_C) begin
                    state_n  = LOST;
                    miss_inc = 1'b1;
                end
            end
            LOST: begin
                if (rise) begin
                    state_n = MEASURE;
                    match_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        // A clear wins over a simultaneous lock exit
        if (I_CLR)         miss_n = 8'd0;
        else if (miss_inc) miss_n = sat_inc_miss(O_MISS_CNT);
        else               miss_n = O_MISS_CNT;
    end

    // Output stage: tick, period and miss count register on the same edge as the FSM
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            match        <= '0;
            cnt          <= '0;
            O_TICK       <= 1'b0;
            O_PERIOD     <= '0;
            O_PERIOD_VLD <= 1'b0;
            O_MISS_CNT   <= 8'd0;
        end else begin
            match        <= match_n;
            cnt          <= rise ? '0 : sat_inc_cnt(cnt);
            O_TICK       <= rise;
            O_PERIOD_VLD <= per_upd;
            if (per_upd) O_PERIOD <= meas;
            O_MISS_CNT   <= miss_n;
        end
    end

    assign O_LOCKED = (state == LOCKED);
    assign O_LOSS   = (state == LOST);

endmodule

// File: tb/tb_process_clk_monitor.sv
// Directed bench for process_clk_monitor: one record per I_PCLK rising edge, plus hand sequences
// for loss, asynchronous reset and miss-counter saturation.
module tb_process_clk_monitor;

    localparam int CNT_W = 8;
`ifdef PCLK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             I_CLK = 1'b0;
    logic             rst;
    logic             I_PCLK;
    logic             I_CLR;
    logic             O_TICK;
    logic [CNT_W-1:0] O_PERIOD;
    logic             O_PERIOD_VLD;
    logic             O_LOCKED;
    logic             O_LOSS;
    logic [7:0]       O_MISS_CNT;

    always #5 I_CLK = ~I_CLK;

    process_clk_monitor #(
        .EXP_PERIOD(4), .LOCK_COUNT(4), .TIMEOUT(16), .CNT_W(CNT_W)
    ) dut (
        .I_CLK       (I_CLK),
        .rst         (rst),
        .I_PCLK      (I_PCLK),
        .I_CLR       (I_CLR),
        .O_TICK      (O_TICK),
        .O_PERIOD    (O_PERIOD),
        .O_PERIOD_VLD(O_PERIOD_VLD),
        .O_LOCKED    (O_LOCKED),
        .O_LOSS      (O_LOSS),
        .O_MISS_CNT  (O_MISS_CNT)
    );

    // len: cycles until the next rise; remaining fields are the outputs expected on this rise's tick
    typedef struct {
        int len; int clr; int period; int vld; int locked; int loss; int miss;
    } rec_t;

    rec_t tbl[29];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_tick = 0;

    task automatic step();
        @(negedge I_CLK);
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all(input string tag, input int tick, input int period, input int vld,
                           input int locked, input int loss, input int miss);
        chk({tag, ".tick"},   int'(O_TICK),       tick);
        chk({tag, ".period"}, int'(O_PERIOD),     period);
        chk({tag, ".vld"},    int'(O_PERIOD_VLD), vld);
        chk({tag, ".locked"}, int'(O_LOCKED),     locked);
        chk({tag, ".loss"},   int'(O_LOSS),       loss);
        chk({tag, ".miss"},   int'(O_MISS_CNT),   miss);
    endtask

    task automatic run_rec(input int idx);
        rec_t  r;
        string tag;
        r   = tbl[idx];
        tag = $sformatf("rec%0d", idx);
        I_PCLK = 1'b1;
        for (int c = 1; c <= r.len; c++) begin
            step();
            if (c == LAT) begin
                last_tick = cyc;
                chk_all(tag, 1, r.period, r.vld, r.locked, r.loss, r.miss);
            end else begin
                chk({tag, ".idle_tick"}, int'(O_TICK), 0);
                chk({tag, ".idle_vld"},  int'(O_PERIOD_VLD), 0);
            end
            I_CLR = (c == LAT - 1 && r.clr != 0);
            if (c == r.len / 2) I_PCLK = 1'b0;
        end
    endtask

    task automatic drive_period(input int len);
        I_PCLK = 1'b1;
        for (int c = 1; c <= len; c++) begin
            step();
            if (c == len / 2) I_PCLK = 1'b0;
        end
    endtask

    initial begin
        //          len clr per vld lck loss miss
        tbl[0]  = '{4, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{4, 0, 4, 1, 0, 0, 0};
        tbl[2]  = '{4, 0, 4, 1, 0, 0, 0};
        tbl[3]  = '{4, 0, 4, 1, 0, 0, 0};
        tbl[4]  = '{4, 0, 4, 1, 1, 0, 0};
        tbl[5]  = '{6, 0, 4, 1, 1, 0, 0};
        tbl[6]  = '{4, 0, 6, 1, 0, 0, 1};
        tbl[7]  = '{4, 0, 4, 1, 0, 0, 1};
        tbl[8]  = '{4, 0, 4, 1, 0, 0, 1};
        tbl[9]  = '{4, 0, 4, 1, 0, 0, 1};
        tbl[10] = '{4, 0, 4, 1, 1, 0, 1};
        tbl[11] = '{4, 0, 4, 1, 1, 0, 1};
        tbl[12] = '{4, 0, 4, 0, 0, 0, 2};
        tbl[13] = '{4, 0, 4, 1, 0, 0, 2};
        tbl[14] = '{4, 0, 4, 1, 0, 0, 2};
        tbl[15] = '{4, 0, 4, 1, 0, 0, 2};
        tbl[16] = '{4, 0, 4, 1, 1, 0, 2};
        tbl[17] = '{4, 0, 0, 0, 0, 0, 0};
        tbl[18] = '{4, 0, 4, 1, 0, 0, 0};
        tbl[19] = '{4, 0, 4, 1, 0, 0, 0};
        tbl[20] = '{4, 0, 4, 1, 0, 0, 0};
        tbl[21] = '{6, 0, 4, 1, 1, 0, 0};
        tbl[22] = '{4, 0, 6, 1, 0, 0, 1};
        tbl[23] = '{4, 0, 4, 1, 0, 0, 1};
        tbl[24] = '{4, 0, 4, 1, 0, 0, 1};
        tbl[25] = '{4, 0, 4, 1, 0, 0, 1};
        tbl[26] = '{6, 0, 4, 1, 1, 0, 1};
        tbl[27] = '{4, 1, 6, 1, 0, 0, 0};
        tbl[28] = '{4, 0, 5, 1, 0, 0, 255};

        rst    = 1'b1;
        I_PCLK = 1'b0;
        I_CLR  = 1'b0;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (3) step();

        // Acquire lock, break it with one long period, relock
        for (int i = 0; i <= 11; i++) run_rec(i);

        // I_PCLK held low after a locked tick
        while (cyc < last_tick + 15) step();
        chk("loss_pre.loss",   int'(O_LOSS),     0);
        chk("loss_pre.locked", int'(O_LOCKED),   1);
        chk("loss_pre.miss",   int'(O_MISS_CNT), 1);
        step();
        chk("loss.loss",   int'(O_LOSS),     1);
        chk("loss.locked", int'(O_LOCKED),   0);
        chk("loss.miss",   int'(O_MISS_CNT), 2);

        for (int i = 12; i <= 16; i++) run_rec(i);

        // Asynchronous reset between clock edges while locked
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        step();

        for (int i = 17; i <= 27; i++) run_rec(i);

        // 300 lock exits; the counter must stop at 255
        for (int i = 0; i < 300; i++) begin
            if (i > 0) drive_period(4);
            repeat (3) drive_period(4);
            drive_period(5);
        end
        run_rec(28);
        repeat (4) step();
        chk("sat_hold.miss", int'(O_MISS_CNT), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
